// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter: round-robin read sharing of the system-ID slave between NUM_REQ
// requesters, with a boot probe that caches and checks the ID and timestamp words.
module sysid_read_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd0,
    parameter bit          CHECK_TS    = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0] rvalid,
    output logic [31:0]        rdata,
    output logic               sid_address,
    input  logic [31:0]        sid_readdata,
    output logic               boot_done,
    output logic               id_ok,
    output logic [31:0]        id_word,
    output logic [31:0]        ts_word
);

    localparam int unsigned SelW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StBootId,
        StBootTs,
        StArb,
        StResp
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] addr_q;
    logic [SelW-1:0]    rr_ptr_q;
    logic [SelW-1:0]    sel_q;

    logic [NUM_REQ-1:0] clr_mask;
    logic [NUM_REQ-1:0] pending_kept;
    logic [NUM_REQ-1:0] capture;
    logic [SelW-1:0]    idx;
    logic [SelW-1:0]    pick;
    logic               pick_valid;
    logic               id_match;
    logic               ts_match;

    // Pending bookkeeping: the served bit is cleared first, so a same-edge request re-pends
    always_comb begin
        clr_mask = '0;
        if (state_q == StResp) begin
            clr_mask[sel_q] = 1'b1;
        end
        pending_kept = pending_q & ~clr_mask;
        capture      = req & ~pending_kept;
    end

    // Round-robin pick: first pending index after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        idx        = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = SelW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_valid && pending_q[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    // Boot probe comparison: the ID is already cached, the timestamp is still on the bus
    always_comb begin
        id_match = (id_word == EXPECTED_ID);
        ts_match = !CHECK_TS || (sid_readdata == EXPECTED_TS);
    end

    // Request capture, boot probe and arbitration FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StBootId;
            pending_q   <= '0;
            addr_q      <= '0;
            rr_ptr_q    <= SelW'(NUM_REQ - 1);
            sel_q       <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            sid_address <= 1'b0;
            boot_done   <= 1'b0;
            id_ok       <= 1'b0;
            id_word     <= '0;
            ts_word     <= '0;
        end else begin
            rvalid    <= '0;
            pending_q <= pending_kept | req;
            addr_q    <= (addr_q & ~capture) | (req_addr & capture);
            unique case (state_q)
                StBootId: begin
                    id_word     <= sid_readdata;
                    sid_address <= 1'b1;
                    state_q     <= StBootTs;
                end
                StBootTs: begin
                    ts_word   <= sid_readdata;
                    boot_done <= 1'b1;
                    id_ok     <= id_match && ts_match;
                    state_q   <= StArb;
                end
                StArb: begin
                    if (pick_valid) begin
                        sel_q       <= pick;
                        sid_address <= addr_q[pick];
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    rdata         <= sid_readdata;
                    rvalid[sel_q] <= 1'b1;
                    rr_ptr_q      <= sel_q;
                    state_q       <= StArb;
                end
                default: state_q <= StBootId;
            endcase
        end
    end

endmodule
